// File: rtl/shift_register_piso_tx.sv
// Parallel-in/serial-out transmitter: LSB first, one strobe per CLK_DIV clocks.
// Define SHIFT_REGISTER_PISO_TX_BACK2BACK_EN for gapless back-to-back frames.
module shift_register_piso_tx #(
    parameter int WIDTH   = 8,
    parameter int CLK_DIV = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             serial_out,
    output logic             shift_en_out,
    output logic             busy,
    output logic             frame_done
);

    localparam int BW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DW-1:0]    div_cnt_q, div_cnt_d;
    logic             done_q, done_d;

    logic strobe;
    logic last_bit;
    logic accept;

    assign strobe   = (state_q == SHIFT) && (div_cnt_q == DIV_LAST);
    assign last_bit = (bit_cnt_q == BIT_LAST);

`ifdef SHIFT_REGISTER_PISO_TX_BACK2BACK_EN
    // The final strobe edge can also take the next word.
    assign load_ready = (state_q == IDLE) || (strobe && last_bit);
`else
    assign load_ready = (state_q == IDLE);
`endif

    assign accept       = load_valid && load_ready;
    assign serial_out   = shift_q[0];
    assign shift_en_out = strobe;
    assign busy         = (state_q == SHIFT);
    assign frame_done   = done_q;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        div_cnt_d = div_cnt_q;
        done_d    = strobe && last_bit;
        if (accept) begin
            state_d   = SHIFT;
            shift_d   = load_data;
            bit_cnt_d = '0;
            div_cnt_d = '0;
        end else if (strobe) begin
            shift_d   = {1'b0, shift_q[WIDTH-1:1]};
            div_cnt_d = '0;
            if (last_bit) begin
                state_d   = IDLE;
                bit_cnt_d = '0;
            end else begin
                bit_cnt_d = bit_cnt_q + BW'(1);
            end
        end else if (state_q == SHIFT) begin
            div_cnt_d = div_cnt_q + DW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            div_cnt_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            div_cnt_q <= div_cnt_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_shift_register_piso_tx.sv
// Randomized bench: CLK_DIV=1 and CLK_DIV=3 instances against a frame-timing model.
// Honours SHIFT_REGISTER_PISO_TX_BACK2BACK_EN like the design.
module tb_shift_register_piso_tx;

    localparam int W = 8;
`ifdef SHIFT_REGISTER_PISO_TX_BACK2BACK_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [1:0]   lv;
    logic [W-1:0] ld [2];
    wire  [1:0]   rdy, ser, stb, bsy, dne;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        shift_register_piso_tx #(
            .WIDTH  (W),
            .CLK_DIV((g == 0) ? 1 : 3)
        ) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .load_valid  (lv[g]),
            .load_data   (ld[g]),
            .load_ready  (rdy[g]),
            .serial_out  (ser[g]),
            .shift_en_out(stb[g]),
            .busy        (bsy[g]),
            .frame_done  (dne[g])
        );
    end

    int checks = 0;
    int failures = 0;
    int e = 0;

    bit           cur_v [2];
    int           cur_s [2];
    logic [W-1:0] cur_w [2];
    bit           dn_v  [2];
    int           dn_e  [2];
    logic [W-1:0] dn_w  [2];
    logic [W-1:0] rx    [2];
    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];
    bit           gaps = 1'b0;

    task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at edge %0d", tag, got, exp, e);
        end
    endtask

    function automatic int dv(int g);
        return (g == 0) ? 1 : 3;
    endfunction

    function automatic int qsize(int g);
        return (g == 0) ? q0.size() : q1.size();
    endfunction

    function automatic bit exp_ready(int g);
        int wd = W * dv(g);
        if (!cur_v[g] || (e - cur_s[g]) >= wd) return 1'b1;
        return B2B && ((e - cur_s[g]) == wd - 1);
    endfunction

    function automatic bit pending();
        return (qsize(0) != 0) || (qsize(1) != 0) || cur_v[0] || cur_v[1];
    endfunction

    task automatic clear_model();
        for (int g = 0; g < 2; g++) begin
            cur_v[g] = 1'b0;
            dn_v[g]  = 1'b0;
            rx[g]    = '0;
        end
    endtask

    task automatic drive();
        for (int g = 0; g < 2; g++) begin
            lv[g] = (qsize(g) != 0) && (!gaps || ($urandom_range(3) != 0));
            if (qsize(g) != 0) ld[g] = (g == 0) ? q0[0] : q1[0];
            else ld[g] = W'($urandom);
        end
    endtask

    task automatic tick();
        bit acc [2];
        @(posedge clk);
        for (int g = 0; g < 2; g++) acc[g] = rst_n && lv[g] && exp_ready(g);
        e++;
        for (int g = 0; g < 2; g++) begin
            int wd = W * dv(g);
            if (cur_v[g] && e >= cur_s[g] + wd) begin
                dn_v[g]  = 1'b1;
                dn_e[g]  = cur_s[g] + wd;
                dn_w[g]  = cur_w[g];
                cur_v[g] = 1'b0;
            end
            if (acc[g]) begin
                cur_v[g] = 1'b1;
                cur_s[g] = e;
                cur_w[g] = ld[g];
                if (g == 0) void'(q0.pop_front());
                else void'(q1.pop_front());
            end
        end
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            int  d = dv(g);
            int  o = e - cur_s[g];
            bit  act = cur_v[g];
            bit  xdone = dn_v[g] && (dn_e[g] == e);
            check_eq($sformatf("busy%0d", g), bsy[g], act);
            check_eq($sformatf("strobe%0d", g), stb[g], act && (o % d == d - 1));
            check_eq($sformatf("serial%0d", g), ser[g], act ? cur_w[g][o / d] : 1'b0);
            check_eq($sformatf("ready%0d", g), rdy[g], exp_ready(g));
            check_eq($sformatf("done%0d", g), dne[g], xdone);
            if (xdone) check_eq($sformatf("word%0d", g), rx[g], dn_w[g]);
            if (stb[g] === 1'b1) rx[g] = {ser[g], rx[g][W-1:1]};
        end
        drive();
    endtask

    task automatic drain(int budget);
        int n = 0;
        while (pending() && n < budget) begin
            tick();
            n++;
        end
        check_eq("drain", 32'(pending()), 32'd0);
    endtask

    initial begin
        logic [W-1:0] dir [6];
        dir = '{8'hA5, 8'h81, 8'h0F, 8'hFF, 8'h3C, 8'hC3};
        lv = '0;
        ld[0] = '0;
        ld[1] = '0;
        clear_model();
        #1;
        for (int g = 0; g < 2; g++) begin
            check_eq($sformatf("rst_ready%0d", g), rdy[g], 1'b1);
            check_eq($sformatf("rst_outs%0d", g), {ser[g], stb[g], bsy[g], dne[g]}, 4'b0);
        end
        tick();
        tick();
        rst_n = 1'b1;

        foreach (dir[i]) begin
            q0.push_back(dir[i]);
            q1.push_back(dir[i]);
        end
        drive();
        drain(600);
        tick();
        tick();

        q0.push_back(8'h5A);
        q1.push_back(8'h5A);
        drive();
        begin
            int n = 0;
            while (!(cur_v[0] && (e - cur_s[0]) == 3) && n < 50) begin
                tick();
                n++;
            end
            check_eq("reach3", 32'(cur_v[0] && (e - cur_s[0]) == 3), 32'd1);
        end
        rst_n = 1'b0;
        clear_model();
        lv = '0;
        #1;
        for (int g = 0; g < 2; g++) begin
            check_eq($sformatf("abort_ready%0d", g), rdy[g], 1'b1);
            check_eq($sformatf("abort_outs%0d", g), {ser[g], stb[g], bsy[g], dne[g]}, 4'b0);
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3 * W + 4; i++) tick();

        gaps = 1'b1;
        for (int i = 0; i < 60; i++) begin
            q0.push_back(W'($urandom));
            q1.push_back(W'($urandom));
        end
        drive();
        drain(8000);
        for (int i = 0; i < 4; i++) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shift_register_piso_tx.md
Name: shift_register_piso_tx

Overview:
- Parallel-in/serial-out transmitter; the sending end of the serial link whose receiving end is the team's SIPO shift register.
- Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out LSB first, one bit per CLK_DIV clocks.
- Drives a one-cycle shift strobe per bit. A same-clock SIPO of equal WIDTH (serial bit into MSB, right shift) holds the original word after WIDTH strobes.

Parameters:
- WIDTH, 8, word width in bits; must be at least 2.
- CLK_DIV, 1, clocks per serial bit; must be at least 1; 1 means one bit per clock.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst_n  input  1  asynchronous reset, active low.
- load_valid  input  1  load_data is valid this cycle.
- load_data  input  WIDTH  word to transmit.
- load_ready  output  1  block accepts a word this cycle.
- serial_out  output  1  current serial bit, LSB first.
- shift_en_out  output  1  one-cycle strobe; the receiver samples serial_out at the clock edge ending this cycle.
- busy  output  1  a frame is in progress.
- frame_done  output  1  one-cycle pulse after the last bit is strobed.

Behaviour:
- Reset (rst_n low, asynchronous) forces: state IDLE, shift register 0, bit and divider counters 0.
- Output values under reset: serial_out 0, shift_en_out 0, busy 0, frame_done 0, load_ready 1.
- A reset in the middle of a frame aborts the frame immediately. No frame_done is produced and no further strobes occur.
- States are IDLE and SHIFT.
- IDLE:
  - load_ready = 1, busy = 0, shift_en_out = 0.
  - Accept on the edge where load_valid && load_ready: shift_reg <= load_data, bit_cnt <= 0, div_cnt <= 0, go to SHIFT.
- SHIFT:
  - busy = 1; load_ready = 0, except as allowed by the optional feature.
  - serial_out = shift_reg[0], taken directly from the register.
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - shift_en_out = (state == SHIFT) && (div_cnt == CLK_DIV-1), decoded from registers only.
- On each strobe edge:
  - shift_reg <= {1'b0, shift_reg[WIDTH-1:1]}.
  - bit_cnt increments.
  - If bit_cnt == WIDTH-1 on that edge: go to IDLE and register frame_done = 1 for exactly the next cycle.
- Timing with the word accepted at edge N:
  - bit0 is valid on serial_out from edge N.
  - The first strobe falls in the cycle ending at edge N+CLK_DIV.
  - The frame occupies exactly WIDTH*CLK_DIV cycles in SHIFT.
- load_valid while load_ready = 0 is ignored. The in-flight data and counters must not change.
- After a full frame the shift register reads 0, so serial_out idles at 0.
- Counter widths: bit_cnt is $clog2(WIDTH) bits and div_cnt is $clog2(CLK_DIV) bits, each with a minimum of 1 bit. The CLK_DIV == 1 case must give a strobe every SHIFT cycle.
- Without the optional feature, consecutive frames are separated by at least one IDLE cycle with no strobe. frame_done is high in that IDLE cycle.

Optional Feature:
- Macro: SHIFT_REGISTER_PISO_TX_BACK2BACK_EN.
- Defined:
  - load_ready is also 1 during the final strobe cycle of a frame (SHIFT, bit_cnt == WIDTH-1, div_cnt == CLK_DIV-1).
  - An accept on that edge loads the new word, clears both counters and stays in SHIFT. Strobes continue with no gap.
  - frame_done still pulses one cycle for the finished frame.
  - busy stays 1.
- Undefined: load_ready is 1 only in IDLE, giving the one-idle-cycle gap described in Behaviour.

Test Plan:
- WIDTH=8, CLK_DIV=1, load 0xA5 -> serial_out 1,0,1,0,0,1,0,1 on 8 consecutive strobe cycles. A paired SIPO then holds 0xA5. frame_done is high for 1 cycle after the 8th strobe, with busy 0 in that cycle.
- WIDTH=8, CLK_DIV=3, load 0x81 -> one strobe every 3rd cycle and busy for 24 cycles. serial_out is 1 for the first bit period, 0 for the next 6 bit periods, then 1. The SIPO reads 0x81.
- Hold load_valid high with 0xFF during a 0x0F frame -> load_ready is 0 throughout. Exactly 0x0F is received, then 0xFF is accepted in the following IDLE cycle.
- Pulse rst_n low after 3 strobes of 0x5A -> all outputs drop to their reset values at once. No frame_done and no more strobes. load_ready is 1 after release.
- Load 0x3C then 0xC3 with the macro defined -> 16 consecutive strobes and two frame_done pulses. Without the macro -> 8 strobes, a 1-cycle gap, then 8 strobes. Both words are received intact.
